// File: rtl/coreriscv_axi4_grant_finish_unit_pkg.sv
// Shared types and constants for the grant/finish unit: grant beat layout,
// finish message layout and grant-type decode helpers.
package coreriscv_axi4_grant_finish_unit_pkg;

  localparam int DATA_BEATS = 8;
  localparam int BEAT_W     = $clog2(DATA_BEATS);

  localparam logic [3:0] G_TYPE_DATA_BLOCK  = 4'h5;
  localparam logic [3:0] G_TYPE_VOL_ACK     = 4'h0;
  localparam logic [3:0] G_TYPE_CUSTOM_DATA = 4'h0;

  typedef struct packed {
    logic [BEAT_W-1:0] addr_beat;
    logic [1:0]        client_xact_id;
    logic              manager_xact_id;
    logic              is_builtin_type;
    logic [3:0]        g_type;
    logic [63:0]       data;
  } grant_t;

  localparam int GRANT_W = $bits(grant_t);

  // One grant FIFO entry: the grant fields plus last-beat tag and source index.
  typedef struct packed {
    grant_t bits;
    logic   last;
    logic   source;
  } gnt_beat_t;

  localparam int GNT_BEAT_W = $bits(gnt_beat_t);

  typedef struct packed {
    logic manager_xact_id;
    logic source;
  } fin_t;

  localparam int FIN_W = $bits(fin_t);

  function automatic logic has_data(input logic is_builtin, input logic [3:0] g_type);
    return is_builtin ? (g_type == G_TYPE_DATA_BLOCK) : (g_type == G_TYPE_CUSTOM_DATA);
  endfunction

  // Built-in voluntary acks are the only grants that never need a Finish.
  function automatic logic need_fin(input logic is_builtin, input logic [3:0] g_type);
    return !(is_builtin && (g_type == G_TYPE_VOL_ACK));
  endfunction

endpackage

// File: rtl/coreriscv_axi4_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is driven straight from storage.
// Enqueue is refused while full, even if the head dequeues in the same cycle.
module coreriscv_axi4_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (AW > 0) ? AW : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wptr, rptr;
  logic [IW-1:0]               widx, ridx;
  logic                        full, empty, enq_fire, deq_fire;

  generate
    if (AW == 0) begin : g_one
      assign widx = '0;
      assign ridx = '0;
    end else begin : g_many
      assign widx = wptr[AW-1:0];
      assign ridx = rptr[AW-1:0];
    end
  endgenerate

  assign empty     = (wptr == rptr);
  assign full      = ((wptr - rptr) == (AW+1)'(DEPTH));
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign deq_data  = mem[ridx];
  assign enq_fire  = enq_valid && !full;
  assign deq_fire  = deq_ready && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq_fire) wptr <= wptr + 1'b1;
      if (deq_fire) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem[widx] <= enq_data;
  end

endmodule

// File: rtl/coreriscv_axi4_grant_finish_unit.sv
// Buffers arbitrated grant beats toward the client, tags message ends, emits
// Finish messages toward the manager and flags out-of-order data beats.
module coreriscv_axi4_grant_finish_unit
  import coreriscv_axi4_grant_finish_unit_pkg::*;
#(
  parameter int GNT_DEPTH = 2,
  parameter int FIN_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              io_in_ready,
  input  logic              io_in_valid,
  input  logic [BEAT_W-1:0] io_in_bits_addr_beat,
  input  logic [1:0]        io_in_bits_client_xact_id,
  input  logic              io_in_bits_manager_xact_id,
  input  logic              io_in_bits_is_builtin_type,
  input  logic [3:0]        io_in_bits_g_type,
  input  logic [63:0]       io_in_bits_data,
  input  logic              io_in_chosen,
  input  logic              io_out_ready,
  output logic              io_out_valid,
  output logic [BEAT_W-1:0] io_out_bits_addr_beat,
  output logic [1:0]        io_out_bits_client_xact_id,
  output logic              io_out_bits_manager_xact_id,
  output logic              io_out_bits_is_builtin_type,
  output logic [3:0]        io_out_bits_g_type,
  output logic [63:0]       io_out_bits_data,
  output logic              io_out_last,
  output logic              io_out_source,
  input  logic              io_fin_ready,
  output logic              io_fin_valid,
  output logic              io_fin_bits_manager_xact_id,
  output logic              io_fin_bits_source,
  output logic              io_err_beat
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

  logic [BEAT_W-1:0] cnt;
  logic              in_has_data, in_need_fin, in_last, in_fire, fin_enq;
  logic              gnt_enq_ready, fin_enq_ready;
  gnt_beat_t         gnt_in, gnt_out;
  fin_t              fin_in, fin_out;

  assign in_has_data = has_data(io_in_bits_is_builtin_type, io_in_bits_g_type);
  assign in_need_fin = need_fin(io_in_bits_is_builtin_type, io_in_bits_g_type);
  assign in_last     = !in_has_data || (cnt == LAST_BEAT);

  // A last beat waits for finish space so every completed grant gets its Finish.
  assign io_in_ready = gnt_enq_ready && !(in_last && in_need_fin && !fin_enq_ready);
  assign in_fire     = io_in_valid && io_in_ready;
  assign fin_enq     = in_fire && in_last && in_need_fin;

  always_comb begin
    gnt_in                      = '0;
    gnt_in.bits.addr_beat       = io_in_bits_addr_beat;
    gnt_in.bits.client_xact_id  = io_in_bits_client_xact_id;
    gnt_in.bits.manager_xact_id = io_in_bits_manager_xact_id;
    gnt_in.bits.is_builtin_type = io_in_bits_is_builtin_type;
    gnt_in.bits.g_type          = io_in_bits_g_type;
    gnt_in.bits.data            = io_in_bits_data;
    gnt_in.last                 = in_last;
    gnt_in.source               = io_in_chosen;
    fin_in                      = '0;
    fin_in.manager_xact_id      = io_in_bits_manager_xact_id;
    fin_in.source               = io_in_chosen;
  end

  // Beat counter and sticky order check; data is forwarded even on error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      io_err_beat <= 1'b0;
    end else if (in_fire && in_has_data) begin
      cnt <= cnt + 1'b1;
      if (io_in_bits_addr_beat != cnt) io_err_beat <= 1'b1;
    end
  end

  coreriscv_axi4_sync_fifo #(.WIDTH(GNT_BEAT_W), .DEPTH(GNT_DEPTH)) u_gnt_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .enq_valid (in_fire),
    .enq_ready (gnt_enq_ready),
    .enq_data  (gnt_in),
    .deq_valid (io_out_valid),
    .deq_ready (io_out_ready),
    .deq_data  (gnt_out)
  );

  coreriscv_axi4_sync_fifo #(.WIDTH(FIN_W), .DEPTH(FIN_DEPTH)) u_fin_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .enq_valid (fin_enq),
    .enq_ready (fin_enq_ready),
    .enq_data  (fin_in),
    .deq_valid (io_fin_valid),
    .deq_ready (io_fin_ready),
    .deq_data  (fin_out)
  );

  assign io_out_bits_addr_beat       = gnt_out.bits.addr_beat;
  assign io_out_bits_client_xact_id  = gnt_out.bits.client_xact_id;
  assign io_out_bits_manager_xact_id = gnt_out.bits.manager_xact_id;
  assign io_out_bits_is_builtin_type = gnt_out.bits.is_builtin_type;
  assign io_out_bits_g_type          = gnt_out.bits.g_type;
  assign io_out_bits_data            = gnt_out.bits.data;
  assign io_out_last                 = gnt_out.last;
  assign io_out_source               = gnt_out.source;
  assign io_fin_bits_manager_xact_id = fin_out.manager_xact_id;
  assign io_fin_bits_source          = fin_out.source;

endmodule

// File: tb/tb_coreriscv_axi4_grant_finish_unit.sv
// Directed bench for the grant/finish unit: reset, single/multi-beat grants,
// backpressure on both queues, beat-order error and streaming throughput.
module tb_coreriscv_axi4_grant_finish_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_in_ready, io_in_valid;
  logic [2:0]  io_in_bits_addr_beat;
  logic [1:0]  io_in_bits_client_xact_id;
  logic        io_in_bits_manager_xact_id, io_in_bits_is_builtin_type;
  logic [3:0]  io_in_bits_g_type;
  logic [63:0] io_in_bits_data;
  logic        io_in_chosen;
  logic        io_out_ready, io_out_valid;
  logic [2:0]  io_out_bits_addr_beat;
  logic [1:0]  io_out_bits_client_xact_id;
  logic        io_out_bits_manager_xact_id, io_out_bits_is_builtin_type;
  logic [3:0]  io_out_bits_g_type;
  logic [63:0] io_out_bits_data;
  logic        io_out_last, io_out_source;
  logic        io_fin_ready, io_fin_valid;
  logic        io_fin_bits_manager_xact_id, io_fin_bits_source;
  logic        io_err_beat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  coreriscv_axi4_grant_finish_unit dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .io_in_ready                 (io_in_ready),
    .io_in_valid                 (io_in_valid),
    .io_in_bits_addr_beat        (io_in_bits_addr_beat),
    .io_in_bits_client_xact_id   (io_in_bits_client_xact_id),
    .io_in_bits_manager_xact_id  (io_in_bits_manager_xact_id),
    .io_in_bits_is_builtin_type  (io_in_bits_is_builtin_type),
    .io_in_bits_g_type           (io_in_bits_g_type),
    .io_in_bits_data             (io_in_bits_data),
    .io_in_chosen                (io_in_chosen),
    .io_out_ready                (io_out_ready),
    .io_out_valid                (io_out_valid),
    .io_out_bits_addr_beat       (io_out_bits_addr_beat),
    .io_out_bits_client_xact_id  (io_out_bits_client_xact_id),
    .io_out_bits_manager_xact_id (io_out_bits_manager_xact_id),
    .io_out_bits_is_builtin_type (io_out_bits_is_builtin_type),
    .io_out_bits_g_type          (io_out_bits_g_type),
    .io_out_bits_data            (io_out_bits_data),
    .io_out_last                 (io_out_last),
    .io_out_source               (io_out_source),
    .io_fin_ready                (io_fin_ready),
    .io_fin_valid                (io_fin_valid),
    .io_fin_bits_manager_xact_id (io_fin_bits_manager_xact_id),
    .io_fin_bits_source          (io_fin_bits_source),
    .io_err_beat                 (io_err_beat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic bi, input logic [3:0] gt, input logic [2:0] ab,
                       input logic mg, input logic ch, input logic [63:0] d);
    io_in_valid                = v;
    io_in_bits_is_builtin_type = bi;
    io_in_bits_g_type          = gt;
    io_in_bits_addr_beat       = ab;
    io_in_bits_client_xact_id  = 2'd2;
    io_in_bits_manager_xact_id = mg;
    io_in_chosen               = ch;
    io_in_bits_data            = d;
  endtask

  task automatic do_reset();
    io_in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("rst_fin_valid", 64'(io_fin_valid), 64'd0);
    chk("rst_err_beat", 64'(io_err_beat), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n      = 1'b1;
    io_out_ready = 1'b1;
    io_fin_ready = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 64'd0);
    #1;
    do_reset();
    chk("idle_in_ready", 64'(io_in_ready), 64'd1);

    // Reset mid-message, then a clean 8-beat builtin data grant
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'h5, 3'(i), 1'b0, 1'b0, 64'hA000 + 64'(i));
      tick();
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 4'h5, 3'(i), 1'b1, 1'b1, 64'hB000 + 64'(i));
      tick();
      chk("m8_out_valid", 64'(io_out_valid), 64'd1);
      chk("m8_out_data", io_out_bits_data, 64'hB000 + 64'(i));
      chk("m8_out_last", 64'(io_out_last), 64'(i == 7));
      chk("m8_fin_valid", 64'(io_fin_valid), 64'(i == 7));
    end
    chk("m8_fin_id", 64'(io_fin_bits_manager_xact_id), 64'd1);
    chk("m8_fin_src", 64'(io_fin_bits_source), 64'd1);
    drive(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 64'd0);
    tick();
    chk("m8_fin_drained", 64'(io_fin_valid), 64'd0);
    chk("m8_out_drained", 64'(io_out_valid), 64'd0);
    chk("m8_no_err", 64'(io_err_beat), 64'd0);

    // Single-beat grants: vol-ack has no finish, g_type 3 does
    drive(1'b1, 1'b1, 4'h0, 3'd0, 1'b1, 1'b0, 64'hC0);
    tick();
    chk("ack_out_last", 64'(io_out_last), 64'd1);
    chk("ack_fin_valid", 64'(io_fin_valid), 64'd0);
    drive(1'b1, 1'b1, 4'h3, 3'd0, 1'b1, 1'b1, 64'hC1);
    tick();
    chk("g3_out_last", 64'(io_out_last), 64'd1);
    chk("g3_out_src", 64'(io_out_source), 64'd1);
    chk("g3_fin_valid", 64'(io_fin_valid), 64'd1);
    chk("g3_fin_id", 64'(io_fin_bits_manager_xact_id), 64'd1);
    chk("g3_fin_src", 64'(io_fin_bits_source), 64'd1);
    drive(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 64'd0);
    tick();

    // Grant backpressure: two entries fill, third stalls, order preserved
    io_out_ready = 1'b0;
    drive(1'b1, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 64'hD0);
    #1 chk("bp_rdy0", 64'(io_in_ready), 64'd1);
    tick();
    drive(1'b1, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 64'hD1);
    #1 chk("bp_rdy1", 64'(io_in_ready), 64'd1);
    tick();
    drive(1'b1, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 64'hD2);
    #1 chk("bp_rdy2_full", 64'(io_in_ready), 64'd0);
    tick();
    chk("bp_hold_head", io_out_bits_data, 64'hD0);
    chk("bp_still_full", 64'(io_in_ready), 64'd0);
    io_out_ready = 1'b1;
    tick();
    chk("bp_head1", io_out_bits_data, 64'hD1);
    tick();
    chk("bp_head2", io_out_bits_data, 64'hD2);
    drive(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 64'd0);
    tick();
    chk("bp_empty", 64'(io_out_valid), 64'd0);

    // Finish queue full stalls a finish-requiring last beat
    io_fin_ready = 1'b0;
    drive(1'b1, 1'b1, 4'h3, 3'd0, 1'b1, 1'b0, 64'hE0);
    tick();
    drive(1'b1, 1'b1, 4'h3, 3'd0, 1'b0, 1'b1, 64'hE1);
    tick();
    drive(1'b1, 1'b1, 4'h3, 3'd0, 1'b1, 1'b0, 64'hE2);
    #1 chk("ff_stall", 64'(io_in_ready), 64'd0);
    tick();
    chk("ff_head_src", 64'(io_fin_bits_source), 64'd0);
    chk("ff_head_id", 64'(io_fin_bits_manager_xact_id), 64'd1);
    io_fin_ready = 1'b1;
    tick();
    chk("ff_ready_after_deq", 64'(io_in_ready), 64'd1);
    chk("ff_head2_src", 64'(io_fin_bits_source), 64'd1);
    chk("ff_head2_id", 64'(io_fin_bits_manager_xact_id), 64'd0);
    tick();
    chk("ff_out_third", io_out_bits_data, 64'hE2);
    chk("ff_head3_src", 64'(io_fin_bits_source), 64'd0);
    chk("ff_head3_id", 64'(io_fin_bits_manager_xact_id), 64'd1);
    drive(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 64'd0);
    tick();
    chk("ff_drained", 64'(io_fin_valid), 64'd0);

    // Beat-order error: addr_beat sequence 0,1,3,4,5,6,7,0
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 4'h5, (i < 2) ? 3'(i) : 3'(i + 1), 1'b0, 1'b0, 64'hF000 + 64'(i));
      tick();
      chk("be_err", 64'(io_err_beat), 64'(i >= 2));
      chk("be_data", io_out_bits_data, 64'hF000 + 64'(i));
      chk("be_last", 64'(io_out_last), 64'(i == 7));
    end
    drive(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 64'd0);
    tick();
    chk("be_sticky", 64'(io_err_beat), 64'd1);
    do_reset();

    // Back-to-back custom data grants at full rate
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'b0, 4'h0, 3'(i), 1'(m), 1'(m ^ 1), 64'h1000 * 64'(m + 1) + 64'(i));
        #1 chk("tp_in_ready", 64'(io_in_ready), 64'd1);
        tick();
        chk("tp_data", io_out_bits_data, 64'h1000 * 64'(m + 1) + 64'(i));
        chk("tp_last", 64'(io_out_last), 64'(i == 7));
        chk("tp_fin_valid", 64'(io_fin_valid), 64'(i == 7));
        if (i == 7) begin
          chk("tp_fin_id", 64'(io_fin_bits_manager_xact_id), 64'(m));
          chk("tp_fin_src", 64'(io_fin_bits_source), 64'(m ^ 1));
        end
      end
    end
    drive(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 64'd0);
    tick();
    chk("tp_end_out", 64'(io_out_valid), 64'd0);
    chk("tp_end_err", 64'(io_err_beat), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
